// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, BPC multiplier bits per cycle, signed/unsigned per op.
// Optional early termination on an exhausted multiplier: define SEQ_MULT_EARLY_TERM_EN.
module seq_mult #(
  parameter int SZ  = 32,
  parameter int BPC = 1
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic [SZ-1:0]   a,
  input  logic [SZ-1:0]   b,
  input  logic            sgn,
  input  logic            start,
  output logic [2*SZ-1:0] res,
  output logic            ready,
  output logic            busy
);

  localparam int K  = SZ / BPC;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t          state_q, state_d;
  logic [2*SZ-1:0] areg_q, areg_d;
  logic [SZ-1:0]   mreg_q, mreg_d;
  logic [2*SZ-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [2*SZ-1:0] res_q, res_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic [SZ-1:0]   a_abs, b_abs;
  logic [2*SZ-1:0] pp;
  logic            last_iter;
  logic            m_zero, m_next_zero;

  always_comb begin
    a_abs     = (sgn && a[SZ-1]) ? (~a + SZ'(1)) : a;
    b_abs     = (sgn && b[SZ-1]) ? (~b + SZ'(1)) : b;
    pp        = areg_q * {{(2*SZ-BPC){1'b0}}, mreg_q[BPC-1:0]};
    last_iter = (cnt_q == CW'(K - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Skip remaining iterations once no multiplier bits are left to retire.
    m_zero      = (mreg_q == '0);
    m_next_zero = (mreg_q[SZ-1:BPC] == '0);
`else
    m_zero      = 1'b0;
    m_next_zero = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    mreg_d  = mreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          areg_d  = {{SZ{1'b0}}, a_abs};
          mreg_d  = b_abs;
          neg_d   = sgn & (a[SZ-1] ^ b[SZ-1]);
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!m_zero) begin
          acc_d  = acc_q + pp;
          areg_d = areg_q << BPC;
          mreg_d = mreg_q >> BPC;
          cnt_d  = cnt_q + CW'(1);
        end
        if (m_zero || m_next_zero || last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = neg_q ? (~acc_q + (2*SZ)'(1)) : acc_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      state_q <= S_IDLE;
      areg_q  <= '0;
      mreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      mreg_q  <= mreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign res   = res_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
